// File: rtl/xge_tx_arb_pkg.sv
// Shared types and constants for the packet-granular MAC transmit arbiter.
package xge_tx_arb_pkg;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned MOD_W   = 3;
  localparam int unsigned ID_W    = 3;

  typedef enum logic {ST_IDLE, ST_XFER} state_t;
endpackage

// File: rtl/xge_rr_picker.sv
// Combinational round-robin first-one search starting just above the pointer.
module xge_rr_picker
  import xge_tx_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] idx,
  output logic            found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      if (!found && req[(32'(ptr) + off) % N]) begin
        found = 1'b1;
        idx   = ID_W'((32'(ptr) + off) % N);
      end
    end
  end

endmodule

// File: rtl/xge_tx_arbiter.sv
// Round-robin arbiter that forwards whole packets from NUM_REQ sources onto
// the MAC pkt_tx_* interface, with registered outputs and saturating counters.
module xge_tx_arbiter
  import xge_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk_156m25,
  input  logic                       reset_156m25_n,
  input  logic [NUM_REQ-1:0]         req_en,
  input  logic [NUM_REQ-1:0]         req_val,
  input  logic [NUM_REQ-1:0]         req_sop,
  input  logic [NUM_REQ-1:0]         req_eop,
  input  logic [NUM_REQ*MOD_W-1:0]   req_mod,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_rdy,
  input  logic                       pkt_tx_full,
  output logic                       pkt_tx_val,
  output logic                       pkt_tx_sop,
  output logic                       pkt_tx_eop,
  output logic [MOD_W-1:0]           pkt_tx_mod,
  output logic [DATA_W-1:0]          pkt_tx_data,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy,
  output logic                       err_sop,
  output logic                       err_nosop,
  output logic [NUM_REQ*CNT_W-1:0]   pkt_cnt
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr;
  logic                first_beat;
  logic [CNT_W-1:0]    cnt [NUM_REQ];
  logic [NUM_REQ-1:0]  cand;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_found;
  logic                xfer;
  logic                sel_val, sel_sop, sel_eop;
  logic [MOD_W-1:0]    sel_mod;
  logic [DATA_W-1:0]   sel_data;

  assign cand = req_en & req_val & req_sop;
  assign busy = (state == ST_XFER);

  xge_rr_picker #(.N(NUM_REQ)) u_pick (
    .req   (cand),
    .ptr   (rr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    sel_val  = 1'b0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    sel_mod  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        sel_val  = req_val[i];
        sel_sop  = req_sop[i];
        sel_eop  = req_eop[i];
        sel_mod  = req_mod[MOD_W*i +: MOD_W];
        sel_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_rdy   = '0;
    xfer      = 1'b0;
    case (state)
      ST_IDLE: if (pick_found) state_nxt = ST_XFER;
      ST_XFER: begin
        for (int unsigned i = 0; i < NUM_REQ; i++)
          req_rdy[i] = (ID_W'(i) == grant_id) && !pkt_tx_full;
        xfer = sel_val && !pkt_tx_full;
        if (xfer && sel_eop) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state       <= ST_IDLE;
      grant_id    <= '0;
      rr          <= ID_W'(NUM_REQ - 1);
      first_beat  <= 1'b0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      pkt_tx_data <= '0;
      err_sop     <= 1'b0;
      err_nosop   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      state      <= state_nxt;
      pkt_tx_val <= 1'b0;
      pkt_tx_sop <= 1'b0;
      pkt_tx_eop <= 1'b0;
      err_sop    <= 1'b0;
      err_nosop  <= 1'b0;
      if (state == ST_IDLE && pick_found) begin
        grant_id   <= pick_idx;
        first_beat <= 1'b1;
      end
      // Data/mod hold their last beat when idle; only the qualifiers drop.
      if (xfer) begin
        pkt_tx_val  <= 1'b1;
        pkt_tx_sop  <= sel_sop;
        pkt_tx_eop  <= sel_eop;
        pkt_tx_mod  <= sel_mod;
        pkt_tx_data <= sel_data;
        err_sop     <= !first_beat && sel_sop;
        err_nosop   <= first_beat && !sel_sop;
        first_beat  <= 1'b0;
        if (sel_eop) begin
          rr <= grant_id;
          for (int unsigned i = 0; i < NUM_REQ; i++)
            if (ID_W'(i) == grant_id && cnt[i] != '1)
              cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      pkt_cnt[CNT_W*i +: CNT_W] = cnt[i];
  end

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// Directed bench for xge_tx_arbiter: vector table for single-source packets
// and backpressure, plus hand sequences for arbitration and corner cases.
module tb_xge_tx_arbiter;
  localparam int NR = 4;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NR-1:0]  en, val, sop, eop, rdy;
  logic [NR*3-1:0]  mod;
  logic [NR*64-1:0] data;
  logic           full;
  logic           tx_val, tx_sop, tx_eop, busy, err_sop, err_nosop;
  logic [2:0]     tx_mod, grant_id;
  logic [63:0]    tx_data;
  logic [NR*CW-1:0] pkt_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xge_tx_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .req_en         (en),
    .req_val        (val),
    .req_sop        (sop),
    .req_eop        (eop),
    .req_mod        (mod),
    .req_data       (data),
    .req_rdy        (rdy),
    .pkt_tx_full    (full),
    .pkt_tx_val     (tx_val),
    .pkt_tx_sop     (tx_sop),
    .pkt_tx_eop     (tx_eop),
    .pkt_tx_mod     (tx_mod),
    .pkt_tx_data    (tx_data),
    .grant_id       (grant_id),
    .busy           (busy),
    .err_sop        (err_sop),
    .err_nosop      (err_nosop),
    .pkt_cnt        (pkt_cnt)
  );

  typedef struct packed {
    logic       v, s, e, f;
    logic [7:0] b;
    logic [2:0] m;
    logic [3:0] x_rdy;
    logic       x_val, x_sop, x_eop;
    logic [7:0] x_b;
    logic [2:0] x_m;
    logic       x_busy;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int i, input logic [7:0] b, input logic [2:0] m);
    data[64*i +: 64] = {8{b}};
    mod[3*i +: 3]    = m;
  endtask

  task automatic idle_inputs;
    en = '1; val = '0; sop = '0; eop = '0; full = 1'b0; data = '0; mod = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [CW-1:0] cnt_of(input int i);
    logic [NR*CW-1:0] v;
    v = pkt_cnt;
    return v[CW*i +: CW];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] rdy_s;
    logic       bt [NR];
    int         nsop, neop, cur;

    tbl[0]  = '{1'b1,1'b1,1'b0,1'b0,8'h11,3'd0, 4'b0000, 1'b0,1'b0,1'b0,8'h00,3'd0, 1'b1};
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b0,8'h11,3'd0, 4'b0001, 1'b1,1'b1,1'b0,8'h11,3'd0, 1'b1};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,8'h22,3'd0, 4'b0001, 1'b1,1'b0,1'b0,8'h22,3'd0, 1'b1};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,8'h33,3'd5, 4'b0001, 1'b1,1'b0,1'b1,8'h33,3'd5, 1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,3'd0, 4'b0000, 1'b0,1'b0,1'b0,8'h00,3'd0, 1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,8'h41,3'd0, 4'b0000, 1'b0,1'b0,1'b0,8'h00,3'd0, 1'b1};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b0,8'h41,3'd0, 4'b0001, 1'b1,1'b1,1'b0,8'h41,3'd0, 1'b1};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b1,8'h42,3'd0, 4'b0000, 1'b0,1'b0,1'b0,8'h00,3'd0, 1'b1};
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = tbl[7];
    tbl[11] = '{1'b1,1'b0,1'b0,1'b0,8'h42,3'd0, 4'b0001, 1'b1,1'b0,1'b0,8'h42,3'd0, 1'b1};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0,8'h43,3'd0, 4'b0001, 1'b1,1'b0,1'b0,8'h43,3'd0, 1'b1};
    tbl[13] = '{1'b1,1'b0,1'b1,1'b0,8'h44,3'd7, 4'b0001, 1'b1,1'b0,1'b1,8'h44,3'd7, 1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0,8'h00,3'd0, 4'b0000, 1'b0,1'b0,1'b0,8'h00,3'd0, 1'b0};

    // Reset values
    idle_inputs();
    tick();
    tick();
    chk("rst_tx", {tx_val, tx_sop, tx_eop, tx_mod, tx_data}, '0);
    chk("rst_ctl", {busy, err_sop, err_nosop, grant_id, rdy}, '0);
    chk("rst_cnt", pkt_cnt, '0);
    rst_n = 1'b1;
    tick();

    // Table: 3-beat packet, then 4-beat packet with 4 cycles of backpressure
    for (int r = 0; r < 15; r++) begin
      val[0] = tbl[r].v; sop[0] = tbl[r].s; eop[0] = tbl[r].e; full = tbl[r].f;
      set_beat(0, tbl[r].b, tbl[r].m);
      #1;
      chk($sformatf("tbl%0d_rdy", r), rdy, tbl[r].x_rdy);
      tick();
      chk($sformatf("tbl%0d_val", r), tx_val, tbl[r].x_val);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].x_busy);
      if (tbl[r].x_busy) chk($sformatf("tbl%0d_grant", r), grant_id, 3'd0);
      if (tbl[r].x_val) begin
        chk($sformatf("tbl%0d_frame", r), {tx_sop, tx_eop, tx_mod}, {tbl[r].x_sop, tbl[r].x_eop, tbl[r].x_m});
        chk($sformatf("tbl%0d_data", r), tx_data, {8{tbl[r].x_b}});
      end
      if (r == 4) chk("tbl_cnt0_after1", cnt_of(0), 2'd1);
    end
    chk("tbl_cnt0_after2", cnt_of(0), 2'd2);

    // Round robin: four sources with continuous 2-beat packets
    do_reset();
    nsop = 0; neop = 0; cur = -1;
    for (int i = 0; i < NR; i++) bt[i] = 1'b0;
    for (int c = 0; c < 80 && neop < 8; c++) begin
      for (int i = 0; i < NR; i++) begin
        val[i] = 1'b1; sop[i] = !bt[i]; eop[i] = bt[i];
        set_beat(i, {4'(i), 3'b000, bt[i]}, 3'd0);
      end
      #1;
      rdy_s = rdy;
      tick();
      for (int i = 0; i < NR; i++) if (rdy_s[i]) bt[i] = !bt[i];
      if (tx_val) begin
        if (tx_sop) begin
          chk("rr_order", 64'(tx_data[7:4]), 64'(nsop % NR));
          chk("rr_grant", grant_id, 3'(nsop % NR));
          cur = int'(tx_data[7:4]);
          nsop++;
        end else begin
          chk("rr_no_interleave", 64'(tx_data[7:4]), 64'(cur));
        end
        if (tx_eop) neop++;
      end
    end
    chk("rr_packets_done", 64'(neop), 64'd8);
    val = '0;
    tick();
    for (int i = 0; i < NR; i++) chk($sformatf("rr_cnt%0d", i), cnt_of(i), 2'd2);

    // Back-to-back single-beat packets from source 2; counter saturates at 3
    do_reset();
    val[2] = 1'b1; sop[2] = 1'b1; eop[2] = 1'b1;
    set_beat(2, 8'hC3, 3'd3);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("sb_val%0d", k), tx_val, (k % 2) == 0);
      if ((k % 2) == 0) begin
        chk("sb_frame", {tx_sop, tx_eop, tx_mod, tx_data}, {1'b1, 1'b1, 3'd3, {8{8'hC3}}});
        chk("sb_back_idle", busy, 1'b0);
        chk("sb_grant", grant_id, 3'd2);
      end
    end
    val = '0;
    tick();
    chk("sb_cnt2_sat", cnt_of(2), 2'd3);
    chk("sb_cnt0", cnt_of(0), 2'd0);

    // Mid-packet SOP from source 1, and req_en dropped mid-packet
    do_reset();
    val[1] = 1'b1; sop[1] = 1'b1; set_beat(1, 8'hA1, 3'd0);
    tick();
    chk("es_grant", {busy, grant_id}, {1'b1, 3'd1});
    #1;
    chk("es_rdy", rdy, 4'b0010);
    tick();
    chk("es_beat1", {tx_val, tx_sop, tx_data[7:0], err_sop}, {1'b1, 1'b1, 8'hA1, 1'b0});
    set_beat(1, 8'hA2, 3'd0);
    en[1] = 1'b0;
    tick();
    chk("es_beat2", {tx_val, tx_sop, tx_data[7:0]}, {1'b1, 1'b1, 8'hA2});
    chk("es_err_sop", {err_sop, err_nosop}, 2'b10);
    sop[1] = 1'b0; eop[1] = 1'b1; set_beat(1, 8'hA3, 3'd2);
    tick();
    chk("es_beat3", {tx_val, tx_eop, tx_mod, tx_data[7:0]}, {1'b1, 1'b1, 3'd2, 8'hA3});
    chk("es_err_pulse", err_sop, 1'b0);
    chk("es_done", busy, 1'b0);
    sop[1] = 1'b1; eop[1] = 1'b0; set_beat(1, 8'hA4, 3'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("es_disabled_skip", {busy, tx_val}, 2'b00);
    end
    chk("es_cnt1", cnt_of(1), 2'd1);

    // First granted beat arrives without SOP
    do_reset();
    val[0] = 1'b1; sop[0] = 1'b1; set_beat(0, 8'hB1, 3'd0);
    tick();
    sop[0] = 1'b0;
    tick();
    chk("ns_beat1", {tx_val, tx_sop, tx_data[7:0]}, {1'b1, 1'b0, 8'hB1});
    chk("ns_err", {err_nosop, err_sop}, 2'b10);
    eop[0] = 1'b1; set_beat(0, 8'hB2, 3'd1);
    tick();
    chk("ns_beat2", {tx_val, tx_eop, tx_data[7:0]}, {1'b1, 1'b1, 8'hB2});
    chk("ns_err_pulse", err_nosop, 1'b0);

    // Asynchronous reset during beat 2 of 4 from source 2
    do_reset();
    val[2] = 1'b1; sop[2] = 1'b1; set_beat(2, 8'hD1, 3'd0);
    tick();
    tick();
    sop[2] = 1'b0; set_beat(2, 8'hD2, 3'd0);
    tick();
    chk("rm_pre", {busy, grant_id, tx_val, tx_data[7:0]}, {1'b1, 3'd2, 1'b1, 8'hD2});
    set_beat(2, 8'hD3, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_async_tx", {tx_val, tx_sop, tx_eop, tx_mod, tx_data}, '0);
    chk("rm_async_ctl", {busy, grant_id, rdy, err_sop, err_nosop}, '0);
    chk("rm_async_cnt", pkt_cnt, '0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    val[0] = 1'b1; sop[0] = 1'b1; set_beat(0, 8'hE0, 3'd0);
    val[2] = 1'b1; sop[2] = 1'b1; set_beat(2, 8'hE2, 3'd0);
    tick();
    chk("rm_first_grant", {busy, grant_id}, {1'b1, 3'd0});
    chk("rm_cnt", pkt_cnt, '0);
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xge_tx_arbiter.md
Name: xge_tx_arbiter

Overview:
- Packet-granular round-robin arbiter sharing the MAC transmit packet interface (pkt_tx_data/sop/eop/mod/val, pkt_tx_full backpressure) between NUM_REQ packet sources.
- Sits between the traffic sources and the xge_mac pkt_tx_* inputs, in the clk_156m25 domain.
- Never interleaves packets: a requester holds the interface from SOP beat to EOP beat. Output is registered.
- Keeps per-requester saturating packet counters and flags framing errors.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 16, width of each per-requester packet counter

Ports:
clk_156m25  input  1  core clock; all logic sampled on rising edge
reset_156m25_n  input  1  asynchronous active-low reset
req_en  input  NUM_REQ  per-requester enable; a disabled requester is never newly granted
req_val  input  NUM_REQ  beat valid per requester
req_sop  input  NUM_REQ  start-of-packet per requester
req_eop  input  NUM_REQ  end-of-packet per requester
req_mod  input  NUM_REQ*3  valid-byte modulo per requester, slice i = [3i+2:3i]
req_data  input  NUM_REQ*64  beat data per requester, slice i = [64i+63:64i]
req_rdy  output  NUM_REQ  beat accepted (transfer = req_val[i] & req_rdy[i])
pkt_tx_full  input  1  MAC TX FIFO full
pkt_tx_val  output  1  to MAC
pkt_tx_sop  output  1  to MAC
pkt_tx_eop  output  1  to MAC
pkt_tx_mod  output  3  to MAC
pkt_tx_data  output  64  to MAC
grant_id  output  3  index of the current/last granted requester
busy  output  1  high in XFER state
err_sop  output  1  one-cycle pulse: SOP seen mid-packet from the granted requester
err_nosop  output  1  one-cycle pulse: granted requester's first beat lacked SOP
pkt_cnt  output  NUM_REQ*CNT_W  per-requester count of EOP beats forwarded, saturating

Behaviour:
- Reset, asynchronous: all pkt_tx_* = 0; req_rdy = 0; busy = 0; err_* = 0; pkt_cnt = 0; grant_id = 0; rr pointer = NUM_REQ-1, so requester 0 has first priority.
- FSM states:
  - IDLE: candidates = req_en & req_val & req_sop. Choose the first candidate searching from (rr+1) mod NUM_REQ upward, with wrap. Register grant_id and move to XFER. If there are no candidates, stay in IDLE. req_rdy is all 0 in IDLE.
  - XFER: req_rdy[grant_id] = ~pkt_tx_full (combinational); all other bits are 0. On each transfer, register the beat onto pkt_tx_* the next cycle with pkt_tx_val = 1. pkt_tx_val = 0 on cycles with no transfer. A transfer with req_eop set causes: rr <= grant_id, pkt_cnt[grant_id]++ (saturating at all-ones), and a return to IDLE.
- Latency:
  - Request to grant: 1 cycle.
  - Accepted beat to pkt_tx_*: 1 cycle.
  - Minimum 1 idle cycle between packets on the MAC side.
- Backpressure: pkt_tx_full high means req_rdy = 0 and pkt_tx_val = 0 the next cycle. No beat is ever dropped or duplicated.
- Single-beat packet (SOP & EOP on the same beat): forwarded as one beat, then back to IDLE.
- Granted requester drops req_val mid-packet: stay in XFER, forward nothing, wait. There is no timeout.
- Framing errors:
  - SOP on a non-first transfer in XFER: pulse err_sop; forward the beat unchanged.
  - First transfer without SOP cannot occur, because grant requires SOP. err_nosop covers the case where the requester deasserts sop between grant and transfer: pulse err_nosop and forward the beat unchanged.
- req_en deasserted while a requester is granted: its packet completes. req_en gates new grants only.
- Reset mid-packet: outputs clear immediately, FSM returns to IDLE, and the partial packet is abandoned.
- grant_id is zero-extended to 3 bits.

Decomposition:
- Shared package xge_tx_arb_pkg holds:
  - state enum typedef {ST_IDLE, ST_XFER};
  - MAX_REQ = 8;
  - data/mod width constants (64, 3).
- One sub-module, xge_rr_picker: combinational round-robin first-one search given a request vector and a pointer. It returns the index and a found flag.

Test Plan:
- Single requester 0 sends a 3-beat packet (data 0x11.., 0x22.., 0x33.., eop mod=5), full=0 → grant after 1 cycle; pkt_tx shows SOP 0x11.., 0x22.., EOP 0x33.. with mod=5 on consecutive cycles; pkt_cnt[0] = 1.
- Requesters 0–3 all hold 2-beat packets continuously → grant order 0,1,2,3,0; no interleaving; each pkt_cnt = 2 after 8 packets.
- pkt_tx_full held high for 4 cycles mid-packet → req_rdy low for exactly those 4 cycles and pkt_tx_val = 0 (one cycle later); all beats delivered in order with no loss.
- Requester 2 sends a single-beat packet (SOP=EOP=1, mod=3) back-to-back → one beat per packet, 1 idle cycle between packets, FSM returns to IDLE each time.
- Granted requester 1 asserts SOP on its 2nd beat → err_sop pulses for 1 cycle and the beat is forwarded; req_en[1]=0 mid-packet lets the packet finish, after which requester 1 is skipped.
- Reset asserted during beat 2 of 4 → all outputs 0 asynchronously; after release, requester 0 is granted first and pkt_cnt = 0.
